// File: rtl/alu_seq.sv
// Operand/writeback sequencer wrapped around the 4-bit combinational alu.
// Optional macro ALU_SEQ_COND_EN: cond-bit instructions are skipped while flags.Z is clear.
module alu_seq #(
    parameter  int RF_AW = 2,
    localparam int IW    = 10 + 2*RF_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IW-1:0]    in_instr,
    output logic             in_ready,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [3:0]       alu_sel,
    input  logic [3:0]       alu_out,
    input  logic             alu_c,
    input  logic             alu_z,
    input  logic             alu_v,
    output logic             done,
    output logic [3:0]       result,
    output logic [2:0]       flags,
    input  logic [RF_AW-1:0] dbg_addr,
    output logic [3:0]       dbg_data
);

    localparam int NREG = 2**RF_AW;

    typedef struct packed {
        logic             cond;
        logic             use_imm;
        logic [3:0]       op;
        logic [RF_AW-1:0] rd;
        logic [RF_AW-1:0] ra;
        logic [3:0]       imm;
    } instr_t;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t     state_q, state_d;
    instr_t     ir_q, ir_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [3:0] sel_q, sel_d;
    logic [3:0] res_q, res_d;
    logic [2:0] pfl_q, pfl_d;
    logic [2:0] fl_q, fl_d;
    logic       done_q, done_d;
    logic       skip_q, skip_d;
    logic       rf_we;
    logic [3:0] rf_q [NREG];

    logic [RF_AW-1:0] rb;
    logic             skip_now;

    assign rb = ir_q.imm[RF_AW-1:0];

`ifdef ALU_SEQ_COND_EN
    // flags are {C,V,Z}; the skip decision uses Z as it stands at the READ edge
    assign skip_now = ir_q.cond & ~fl_q[0];
`else
    logic unused_cond;
    assign unused_cond = ir_q.cond;
    assign skip_now    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        res_d   = res_q;
        pfl_d   = pfl_q;
        fl_d    = fl_q;
        skip_d  = skip_q;
        done_d  = 1'b0;
        rf_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ir_d    = instr_t'(in_instr);
                    state_d = READ;
                end
            end
            READ: begin
                a_d     = rf_q[ir_q.ra];
                b_d     = ir_q.use_imm ? ir_q.imm : rf_q[rb];
                sel_d   = ir_q.op;
                skip_d  = skip_now;
                state_d = EXEC;
            end
            EXEC: begin
                if (!skip_q) begin
                    res_d = alu_out;
                    pfl_d = {alu_c, alu_v, alu_z};
                end
                state_d = WB;
            end
            WB: begin
                if (!skip_q) begin
                    rf_we = 1'b1;
                    fl_d  = pfl_q;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            res_q   <= '0;
            pfl_q   <= '0;
            fl_q    <= '0;
            skip_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            res_q   <= res_d;
            pfl_q   <= pfl_d;
            fl_q    <= fl_d;
            skip_q  <= skip_d;
            done_q  <= done_d;
        end
    end

    // The only write port: WB stores the result captured in EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (rf_we) begin
            rf_q[ir_q.rd] <= res_q;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_sel  = sel_q;
    assign done     = done_q;
    assign result   = res_q;
    assign flags    = fl_q;
    assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq; a behavioural 4-bit alu closes the loop around the DUT.
module tb_alu_seq;

    localparam int RF_AW = 2;
    localparam int IW    = 10 + 2*RF_AW;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [IW-1:0]    in_instr;
    logic             in_ready;
    logic [3:0]       alu_a, alu_b, alu_sel, alu_out;
    logic             alu_c, alu_z, alu_v;
    logic             done;
    logic [3:0]       result;
    logic [2:0]       flags;
    logic [RF_AW-1:0] dbg_addr;
    logic [3:0]       dbg_data;

    int nvec = 0;
    int nmis = 0;

    alu_seq #(.RF_AW(RF_AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .alu_c(alu_c), .alu_z(alu_z), .alu_v(alu_v), .done(done), .result(result),
        .flags(flags), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Reference alu: C and V always come from A+B, Z from the selected output
    logic [4:0] sum;
    logic [3:0] o;
    always_comb begin
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        case (alu_sel)
            4'd0:    o = alu_b;
            4'd1:    o = sum[3:0];
            4'd2:    o = alu_a - alu_b;
            4'd4:    o = 4'd0;
            4'd5:    o = alu_a & alu_b;
            4'd6:    o = alu_a | alu_b;
            4'd7:    o = ~alu_a;
            default: o = alu_a;
        endcase
        alu_out = o;
        alu_c   = sum[4];
        alu_v   = (alu_a[3] == alu_b[3]) && (sum[3] != alu_a[3]);
        alu_z   = (o == 4'd0);
    end

    typedef struct {
        logic [IW-1:0] instr;
        logic [1:0]    rd;
        logic [3:0]    res;
        logic [2:0]    fl;
    } vec_t;

    vec_t vecs [14];

    function automatic logic [IW-1:0] mk(input logic c, input logic ui, input logic [3:0] op,
                                         input logic [1:0] rd, input logic [1:0] ra,
                                         input logic [3:0] imm);
        return {c, ui, op, rd, ra, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one instruction from IDLE; returns at the negedge where done is seen
    task automatic run_chk(input string name, input logic [IW-1:0] instr, input logic [1:0] rd,
                           input logic [3:0] res, input logic [2:0] fl, input logic [3:0] regv);
        int lat;
        @(negedge clk);
        chk({name, ".ready"}, in_ready, 1);
        in_valid = 1'b1;
        in_instr = instr;
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_instr = '1;
        lat = 0;
        while (lat < 16) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) break;
        end
        chk({name, ".latency"}, lat, 3);
        dbg_addr = rd;
        #1;
        chk({name, ".result"}, result, res);
        chk({name, ".flags"}, flags, fl);
        chk({name, ".reg"}, dbg_data, regv);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; dbg_addr = '0;

        vecs[0]  = '{mk(0,1,4'd0, 2'd1,2'd0,4'h8), 2'd1, 4'h8, 3'b000};
        vecs[1]  = '{mk(0,1,4'd0, 2'd2,2'd0,4'h8), 2'd2, 4'h8, 3'b000};
        vecs[2]  = '{mk(0,0,4'd1, 2'd3,2'd1,4'h2), 2'd3, 4'h0, 3'b111};
        vecs[3]  = '{mk(0,1,4'd0, 2'd1,2'd0,4'h5), 2'd1, 4'h5, 3'b000};
        vecs[4]  = '{mk(0,1,4'd2, 2'd0,2'd1,4'h5), 2'd0, 4'h0, 3'b011};
        vecs[5]  = '{mk(0,1,4'd7, 2'd2,2'd1,4'h0), 2'd2, 4'hA, 3'b000};
        vecs[6]  = '{mk(0,0,4'd5, 2'd3,2'd1,4'h2), 2'd3, 4'h0, 3'b001};
        vecs[7]  = '{mk(0,0,4'd6, 2'd3,2'd1,4'h2), 2'd3, 4'hF, 3'b000};
        vecs[8]  = '{mk(0,1,4'd4, 2'd0,2'd1,4'h3), 2'd0, 4'h0, 3'b011};
        vecs[9]  = '{mk(0,1,4'd3, 2'd0,2'd1,4'h9), 2'd0, 4'h5, 3'b000};
        vecs[10] = '{mk(0,1,4'd12,2'd1,2'd1,4'hF), 2'd1, 4'h5, 3'b100};
        vecs[11] = '{mk(0,1,4'd1, 2'd1,2'd1,4'hB), 2'd1, 4'h0, 3'b101};
        vecs[12] = '{mk(0,1,4'd1, 2'd1,2'd1,4'h7), 2'd1, 4'h7, 3'b000};
        vecs[13] = '{mk(0,0,4'd1, 2'd0,2'd0,4'h1), 2'd0, 4'hC, 3'b010};

        #2;
        chk("rst.ready", in_ready, 1);
        chk("rst.outs", {alu_a, alu_b, alu_sel, result, flags, done}, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++)
            run_chk($sformatf("vec%0d", i), vecs[i].instr, vecs[i].rd,
                    vecs[i].res, vecs[i].fl, vecs[i].res);

        // Back-to-back with in_valid held: accepts only every 4th cycle, writes land in order
        begin
            logic [3:0] wexp [3];
            int idx = 0, ndone = 0, rbad = 0;
            wexp[0] = 4'h1; wexp[1] = 4'h2; wexp[2] = 4'h3;
            dbg_addr = 2'd3;
            for (int cyc = 0; cyc <= 12; cyc++) begin
                @(negedge clk);
                #1;
                if (done) begin
                    if (ndone < 3) chk($sformatf("b2b.write%0d", ndone), dbg_data, wexp[ndone]);
                    ndone++;
                end
                if (in_ready != ((cyc % 4) == 0)) rbad++;
                if (in_ready && idx < 3) begin
                    in_valid = 1'b1;
                    in_instr = mk(0, 1, 4'd0, 2'd3, 2'd0, wexp[idx]);
                    idx++;
                end else if (in_ready) begin
                    in_valid = 1'b0;
                end else begin
                    in_instr = mk(0, 1, 4'd0, 2'd3, 2'd0, 4'hE);
                end
            end
            chk("b2b.ready_pattern", rbad, 0);
            chk("b2b.done_count", ndone, 3);
            chk("b2b.accepts", idx, 3);
        end

        // Reset during EXEC of an ADD aborts it
        begin
            int nd = 0;
            @(negedge clk);
            in_valid = 1'b1;
            in_instr = mk(0, 1, 4'd1, 2'd2, 2'd1, 4'h3);
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("abort.exec_a", alu_a, 4'h7);
            rst = 1'b1;
            #1;
            chk("abort.outs", {alu_a, alu_b, alu_sel, result, flags, done}, 0);
            chk("abort.ready", in_ready, 1);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (done) nd++;
            end
            rst = 1'b0;
            dbg_addr = 2'd2;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (done) nd++;
            end
            chk("abort.no_done", nd, 0);
            chk("abort.ready_after", in_ready, 1);
            chk("abort.reg2", dbg_data, 4'h0);
        end

        // Conditional execution gated by Z
        run_chk("cond.ldi", mk(0,1,4'd0,2'd1,2'd0,4'h4), 2'd1, 4'h4, 3'b000, 4'h4);
`ifdef ALU_SEQ_COND_EN
        run_chk("cond.skip", mk(1,1,4'd1,2'd2,2'd1,4'h1), 2'd2, 4'h4, 3'b000, 4'h0);
`else
        run_chk("cond.skip", mk(1,1,4'd1,2'd2,2'd1,4'h1), 2'd2, 4'h5, 3'b000, 4'h5);
`endif
        run_chk("cond.zero", mk(0,1,4'd4,2'd0,2'd1,4'h0), 2'd0, 4'h0, 3'b001, 4'h0);
        run_chk("cond.exec", mk(1,1,4'd1,2'd2,2'd1,4'h1), 2'd2, 4'h5, 3'b000, 4'h5);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
